// File: rtl/usb11_send.sv
// Low-speed USB 1.1 transmitter: SYNC, NRZI + bit-stuffed LSB-first payload, then EOP on DP/DM.
// oe rises 1 clk after the first byte is accepted; tx_ready drops while the holding register is full or during EOP.
`timescale 1ns/1ps
module usb11_send #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp,
  output logic       dm,
  output logic       oe,
  output logic       busy,
  output logic       tx_done,
  output logic       underrun
);

  localparam int CW = (CLKS_PER_BIT > 8) ? $clog2(CLKS_PER_BIT) : 3;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [2:0]      r_bit_idx, w_bit_idx;
  logic [2:0]      r_ones, w_ones;
  logic [7:0]      r_shift, w_shift;
  logic            r_last, w_last;
  logic [7:0]      r_hold_dat, w_hold_dat;
  logic            r_hold_last, w_hold_last;
  logic            r_hold_vld, w_hold_vld;
  logic            r_dp, w_dp;
  logic            r_dm, w_dm;
  logic            r_oe, w_oe;
  logic            r_done, w_done;
  logic            r_underrun, w_underrun;
  logic            r_alive;

  logic            w_wrap;
  logic            w_accept;
  logic            w_avail;
  logic [7:0]      w_byte;
  logic            w_byte_last;
  logic [2:0]      w_idx_inc;
  logic            w_send;
  logic            w_bit;
  logic            w_advance;
  logic            w_load;
  logic            w_eop;

  assign w_wrap      = (r_state != S_IDLE) && (r_cnt == LAST_CNT);
  assign tx_ready    = r_alive && !r_hold_vld && (r_state != S_EOP_SE0) && (r_state != S_EOP_J);
  assign w_accept    = tx_valid && tx_ready;
  // A byte arriving exactly at a byte boundary bypasses the holding register.
  assign w_avail     = r_hold_vld || w_accept;
  assign w_byte      = r_hold_vld ? r_hold_dat : tx_data;
  assign w_byte_last = r_hold_vld ? r_hold_last : tx_last;
  assign w_idx_inc   = r_bit_idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_ones      <= 3'd0;
      r_shift     <= 8'd0;
      r_last      <= 1'b0;
      r_hold_dat  <= 8'd0;
      r_hold_last <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_dp        <= 1'b0;
      r_dm        <= 1'b1;
      r_oe        <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
      r_alive     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_bit_idx   <= w_bit_idx;
      r_ones      <= w_ones;
      r_shift     <= w_shift;
      r_last      <= w_last;
      r_hold_dat  <= w_hold_dat;
      r_hold_last <= w_hold_last;
      r_hold_vld  <= w_hold_vld;
      r_dp        <= w_dp;
      r_dm        <= w_dm;
      r_oe        <= w_oe;
      r_done      <= w_done;
      r_underrun  <= w_underrun;
      r_alive     <= 1'b1;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = (r_state == S_IDLE || w_wrap) ? '0 : r_cnt + CW'(1);
    w_bit_idx   = r_bit_idx;
    w_ones      = r_ones;
    w_shift     = r_shift;
    w_last      = r_last;
    w_hold_dat  = r_hold_dat;
    w_hold_last = r_hold_last;
    w_hold_vld  = r_hold_vld;
    w_dp        = r_dp;
    w_dm        = r_dm;
    w_oe        = r_oe;
    w_done      = 1'b0;
    w_underrun  = 1'b0;
    w_send      = 1'b0;
    w_bit       = 1'b0;
    w_advance   = 1'b0;
    w_load      = 1'b0;
    w_eop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_hold_vld) begin
          w_state   = S_SYNC;
          w_oe      = 1'b1;
          w_bit_idx = 3'd0;
          w_send    = 1'b1;
        end
      end
      S_SYNC: begin
        if (w_wrap) begin
          if (r_bit_idx != 3'd7) begin
            w_bit_idx = w_idx_inc;
            w_send    = 1'b1;
            w_bit     = (r_bit_idx == 3'd6);
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          if (r_ones == 3'd6) begin
            w_state = S_STUFF;
            w_send  = 1'b1;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      S_STUFF: begin
        if (w_wrap) w_advance = 1'b1;
      end
      S_EOP_SE0: begin
        if (w_wrap) begin
          if (r_bit_idx == 3'd0) begin
            w_bit_idx = 3'd1;
          end else begin
            w_state = S_EOP_J;
            w_dp    = 1'b0;
            w_dm    = 1'b1;
          end
        end
      end
      S_EOP_J: begin
        if (w_wrap) begin
          w_state = S_IDLE;
          w_oe    = 1'b0;
          w_dp    = 1'b0;
          w_dm    = 1'b1;
          w_done  = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Bit boundary after a data or stuff bit: next data bit, next byte, or end of packet.
    if (w_advance) begin
      if (r_bit_idx != 3'd7) begin
        w_state   = S_DATA;
        w_bit_idx = w_idx_inc;
        w_send    = 1'b1;
        w_bit     = r_shift[w_idx_inc];
      end else if (r_last) begin
        w_eop = 1'b1;
      end else if (w_avail) begin
        w_load = 1'b1;
      end else begin
        w_underrun = 1'b1;
        w_eop      = 1'b1;
      end
    end

    if (w_load) begin
      w_state   = S_DATA;
      w_shift   = w_byte;
      w_last    = w_byte_last;
      w_bit_idx = 3'd0;
      w_send    = 1'b1;
      w_bit     = w_byte[0];
    end

    if (w_eop) begin
      w_state   = S_EOP_SE0;
      w_bit_idx = 3'd0;
      w_dp      = 1'b0;
      w_dm      = 1'b0;
    end

    // NRZI: a 0 toggles the line and breaks the run of ones; a 1 holds the line.
    if (w_send) begin
      if (!w_bit) begin
        w_dp   = ~r_dp;
        w_dm   = ~r_dm;
        w_ones = 3'd0;
      end else begin
        w_ones = r_ones + 3'd1;
      end
    end

    if (w_load) begin
      w_hold_vld = 1'b0;
    end else if (w_accept) begin
      w_hold_vld  = 1'b1;
      w_hold_dat  = tx_data;
      w_hold_last = tx_last;
    end
  end

  assign dp       = r_dp;
  assign dm       = r_dm;
  assign oe       = r_oe;
  assign busy     = (r_state != S_IDLE);
  assign tx_done  = r_done;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_usb11_send.sv
// Bench for usb11_send: random and directed packets compared symbol-by-symbol against a line-level packet model.
`timescale 1ns/1ps
module tb_usb11_send;

  localparam int CPB = 8;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, dp, dm, oe, busy, tx_done, underrun;

  usb11_send #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .dp(dp), .dm(dm), .oe(oe), .busy(busy), .tx_done(tx_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] mon_q[$];
  int         oe_rise_q[$];
  int         done_cnt = 0, und_cnt = 0, both_cnt = 0;
  int         last_und_cyc = 0, last_done_cyc = 0;
  logic       prev_oe = 1'b0;

  always @(negedge clk) begin
    if (oe) mon_q.push_back({dp, dm});
    if (oe && !prev_oe) oe_rise_q.push_back(cyc);
    prev_oe = oe;
    if (tx_done) begin done_cnt++; last_done_cyc = cyc; end
    if (underrun) begin und_cnt++; last_und_cyc = cyc; end
    if (tx_done && underrun) both_cnt++;
  end

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] pkt[$];
  logic [1:0] exp_q[$];

  // Packet model: SYNC bits, payload LSB first with a 0 inserted after six 1s, NRZI from J, then SE0 SE0 J.
  task automatic build_exp();
    logic bits[$];
    logic b;
    int run = 0;
    logic [1:0] lvl = J;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      b = (i == 7);
      bits.push_back(b);
      run = b ? run + 1 : 0;
    end
    for (int k = 0; k < pkt.size(); k++) begin
      for (int j = 0; j < 8; j++) begin
        b = pkt[k][j];
        bits.push_back(b);
        run = b ? run + 1 : 0;
        if (run == 6) begin
          bits.push_back(1'b0);
          run = 0;
        end
      end
    end
    for (int i = 0; i < bits.size(); i++) begin
      if (!bits[i]) lvl = (lvl == J) ? K : J;
      exp_q.push_back(lvl);
    end
    exp_q.push_back(SE0);
    exp_q.push_back(SE0);
    exp_q.push_back(J);
  endtask

  task automatic send_pkt(input bit final_last, output int acc_cyc);
    int t;
    acc_cyc = -1;
    for (int i = 0; i < pkt.size(); i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = pkt[i];
      tx_last  = final_last && (i == pkt.size() - 1);
      t = 0;
      while (!tx_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!tx_ready) begin
        n_checks++;
        $display("FAIL accept_timeout byte %0d: tx_ready=%b after %0d cycles, required 1", i, tx_ready, t);
        tx_valid = 1'b0;
        return;
      end
      if (i == 0) acc_cyc = cyc;
      @(posedge clk);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic run_check(input string name, input bit final_last, input bit exp_und, input int exp_len);
    int s0 = mon_q.size();
    int d0 = done_cnt;
    int u0 = und_cnt;
    int b0 = both_cnt;
    int r0 = oe_rise_q.size();
    int acc, t, got, bad, rise;
    logic [1:0] expv;
    build_exp();
    send_pkt(final_last, acc);
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);

    n_checks++;
    if (done_cnt - d0 !== 1) $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt - d0);
    else n_pass++;

    got = mon_q.size() - s0;
    n_checks++;
    if (got !== exp_q.size() * CPB) $display("FAIL %s oe_len_model: got %0d, required %0d", name, got, exp_q.size() * CPB);
    else n_pass++;

    if (exp_len >= 0) begin
      n_checks++;
      if (got !== exp_len) $display("FAIL %s oe_len: got %0d, required %0d", name, got, exp_len);
      else n_pass++;
    end

    bad = -1;
    for (int k = 0; k < got; k++) begin
      if (k / CPB >= exp_q.size() || mon_q[s0 + k] !== exp_q[k / CPB]) begin
        bad = k;
        break;
      end
    end
    n_checks++;
    if (bad != -1) begin
      expv = (bad / CPB < exp_q.size()) ? exp_q[bad / CPB] : 2'b11;
      $display("FAIL %s line_seq: clk %0d of packet got dp/dm=%b, required %b", name, bad, mon_q[s0 + bad], expv);
    end else n_pass++;

    n_checks++;
    if (und_cnt - u0 !== int'(exp_und)) $display("FAIL %s underrun_pulses: got %0d, required %0d", name, und_cnt - u0, exp_und);
    else n_pass++;

    n_checks++;
    if (both_cnt - b0 !== 0) $display("FAIL %s done_and_underrun_together: got %0d, required 0", name, both_cnt - b0);
    else n_pass++;

    rise = (oe_rise_q.size() > r0) ? oe_rise_q[r0] : -1000;
    n_checks++;
    if (rise - acc !== 2) $display("FAIL %s accept_to_oe: got %0d, required 2", name, rise - acc);
    else n_pass++;

    n_checks++;
    if (last_done_cyc - rise !== exp_q.size() * CPB)
      $display("FAIL %s done_timing: got %0d, required %0d", name, last_done_cyc - rise, exp_q.size() * CPB);
    else n_pass++;

    if (exp_und) begin
      n_checks++;
      if (last_und_cyc - rise !== (8 + 8 * pkt.size()) * CPB)
        $display("FAIL %s underrun_timing: got %0d, required %0d", name, last_und_cyc - rise, (8 + 8 * pkt.size()) * CPB);
      else n_pass++;
    end

    n_checks++;
    if ({oe, dp, dm, busy, tx_ready} !== 5'b00101)
      $display("FAIL %s idle_after: oe/dp/dm/busy/ready got %b, required 00101", name, {oe, dp, dm, busy, tx_ready});
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({oe, dp, dm, busy, tx_done, underrun, tx_ready} !== 7'b0010000)
      $display("FAIL reset_values: oe/dp/dm/busy/done/und/ready got %b, required 0010000",
               {oe, dp, dm, busy, tx_done, underrun, tx_ready});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx_ready, oe, dp, dm} !== 4'b1001) $display("FAIL after_reset: ready/oe/dp/dm got %b, required 1001", {tx_ready, oe, dp, dm});
    else n_pass++;
  endtask

  task automatic test_single_bytes();
    pkt = {8'h00}; run_check("byte_00", 1'b1, 1'b0, 152);
    pkt = {8'hFF}; run_check("byte_FF", 1'b1, 1'b0, 160);
    pkt = {8'hFC}; run_check("stuff_before_eop", 1'b1, 1'b0, 160);
  endtask

  task automatic test_back_to_back();
    pkt = {8'hA5, 8'h3C}; run_check("back_to_back", 1'b1, 1'b0, 216);
    pkt = {8'hFF, 8'hFF}; run_check("ff_ff_stuffing", 1'b1, 1'b0, -1);
  endtask

  task automatic test_underrun();
    pkt = {8'h12}; run_check("underrun", 1'b0, 1'b1, 152);
  endtask

  task automatic test_eop_block();
    int t, acc, d0, r0;
    d0 = done_cnt;
    pkt = {8'h00};
    send_pkt(1'b1, acc);
    t = 0;
    while (!(oe && {dp, dm} == SE0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
    n_checks++;
    if (tx_ready !== 1'b0) $display("FAIL eop_ready: got %b, required 0", tx_ready);
    else n_pass++;
    t = 0;
    while (!tx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if ({tx_ready, busy, tx_done} !== 3'b101) $display("FAIL eop_release: ready/busy/done got %b, required 101", {tx_ready, busy, tx_done});
    else n_pass++;
    r0 = oe_rise_q.size();
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
    t = 0;
    while (done_cnt - d0 < 2 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ((oe_rise_q.size() > r0 ? oe_rise_q[r0] - acc : -1) !== 2)
      $display("FAIL eop_requeue_latency: got %0d, required 2", oe_rise_q.size() > r0 ? oe_rise_q[r0] - acc : -1);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    int acc, d0;
    d0 = done_cnt;
    pkt = {8'hFF, 8'h55};
    send_pkt(1'b1, acc);
    repeat (20) @(negedge clk);
    n_checks++;
    if (oe !== 1'b1) $display("FAIL midreset_active: oe got %b, required 1", oe);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({oe, dp, dm, busy, tx_ready} !== 5'b00100)
      $display("FAIL midreset_values: oe/dp/dm/busy/ready got %b, required 00100", {oe, dp, dm, busy, tx_ready});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx_ready, done_cnt - d0 == 0} !== 2'b11)
      $display("FAIL midreset_release: ready got %b, done pulses %0d, required 1 and 0", tx_ready, done_cnt - d0);
    else n_pass++;
    pkt = {8'h00}; run_check("after_midreset", 1'b1, 1'b0, 152);
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 10; p++) begin
      n = $urandom_range(1, 4);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      run_check($sformatf("random_%0d", p), 1'b1, 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_bytes();
    test_back_to_back();
    test_underrun();
    test_eop_block();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
